// File: rtl/multi_mode_ff_bank_pkg.sv
// ff_pkg: shared mode encoding for the multi-mode flip-flop bank
package ff_pkg;
   typedef enum logic [1:0] {MODE_D, MODE_T, MODE_JK, MODE_SR} mode_e;
endpackage

// File: rtl/multi_mode_ff_bank_if.sv
// multi_mode_ff_bank_if: control/data bundle between a driver and the flip-flop bank
interface multi_mode_ff_bank_if import ff_pkg::*; #(parameter int WIDTH = 4);
   mode_e mode;
   logic [WIDTH-1:0] en;
   logic clr;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic err_clr;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] Q_bar;
   logic [WIDTH-1:0] changed;
   logic sr_err;
   modport master (output mode, en, clr, a, b, err_clr, input Q, Q_bar, changed, sr_err);
   modport slave (input mode, en, clr, a, b, err_clr, output Q, Q_bar, changed, sr_err);
endinterface

// File: rtl/multi_mode_ff_bank_cell.sv
// mm_ff_cell: one D/T/JK/SR channel with change pulse and illegal-SR flag
module mm_ff_cell import ff_pkg::*; #(parameter logic RST_BIT = 1'b0) (
   input  logic  clk,
   input  logic  rst,
   input  mode_e mode,
   input  logic  en,
   input  logic  clr,
   input  logic  a,
   input  logic  b,
   output logic  q,
   output logic  changed,
   output logic  illegal
);
   logic q_prev, q_nxt;
   // JK and SR share set/reset; a^b selects the driven value, a&b toggles only in JK
   always_comb begin
      illegal = en && mode == MODE_SR && a && b;
      q_nxt = !en ? q :
              mode == MODE_D ? a :
              mode == MODE_T ? q ^ a :
              (a ^ b) ? a :
              (a && b && mode == MODE_JK) ? ~q : q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q       <= RST_BIT;
         q_prev  <= RST_BIT;
         changed <= 1'b0;
      end else begin
         q       <= clr ? RST_BIT : q_nxt;
         q_prev  <= q;
         changed <= q ^ q_prev;
      end
   end
endmodule

// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank: WIDTH independent flip-flop channels sharing one mode select
module multi_mode_ff_bank import ff_pkg::*; #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic                clk,
   input logic                rst,
   multi_mode_ff_bank_if.slave bus
);
   logic [WIDTH-1:0] illegal;
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      mm_ff_cell #(.RST_BIT(RESET_VAL[i])) u_cell (
         .clk(clk), .rst(rst), .mode(bus.mode), .en(bus.en[i]), .clr(bus.clr),
         .a(bus.a[i]), .b(bus.b[i]), .q(bus.Q[i]), .changed(bus.changed[i]),
         .illegal(illegal[i])
      );
   end
   assign bus.Q_bar = ~bus.Q;
   // a new illegal SR request wins over err_clr on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) bus.sr_err <= 1'b0;
      else bus.sr_err <= |illegal ? 1'b1 : bus.err_clr ? 1'b0 : bus.sr_err;
   end
endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// tb_multi_mode_ff_bank: scoreboard bench with a bit-level reference model
module tb_multi_mode_ff_bank;
   import ff_pkg::*;
   typedef struct packed {logic [3:0] q; logic [3:0] ch; logic err;} exp_t;
   logic clk, rst;
   multi_mode_ff_bank_if #(.WIDTH(4)) bus ();
   multi_mode_ff_bank #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (.clk(clk), .rst(rst), .bus(bus));
   exp_t sb[$];
   int total = 0, bad = 0;
   logic [3:0] mq = 0, mp = 0, mch = 0;
   logic merr = 0;

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%b want=%b at %0t", name, got, want, $time);
      end
   endtask

   task automatic model_reset();
      mq = 0; mp = 0; mch = 0; merr = 0;
   endtask

   task automatic step(input int m, input logic [3:0] e, ai, bi, input logic c, ec);
      logic [3:0] nq;
      logic ill;
      @(negedge clk);
      bus.mode = mode_e'(m[1:0]); bus.en = e; bus.a = ai; bus.b = bi;
      bus.clr = c; bus.err_clr = ec;
      ill = 0;
      for (int i = 0; i < 4; i++) begin
         nq[i] = mq[i];
         if (e[i]) begin
            if (m == 0) nq[i] = ai[i];
            else if (m == 1) nq[i] = mq[i] ^ ai[i];
            else if (ai[i] && !bi[i]) nq[i] = 1;
            else if (!ai[i] && bi[i]) nq[i] = 0;
            else if (ai[i] && bi[i]) begin
               if (m == 2) nq[i] = !mq[i];
               else ill = 1;
            end
         end
         if (c) nq[i] = 0;
      end
      merr = ill ? 1'b1 : ec ? 1'b0 : merr;
      mch = mq ^ mp;
      mp = mq;
      mq = nq;
      sb.push_back('{q: mq, ch: mch, err: merr});
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("Q", bus.Q, e.q);
            chk("Q_bar", bus.Q_bar, ~e.q);
            chk("changed", bus.changed, e.ch);
            chk("sr_err", {3'b0, bus.sr_err}, {3'b0, e.err});
         end
      end
   end

   task automatic reset_check(input string tag);
      chk({tag, "_Q"}, bus.Q, 4'b0000);
      chk({tag, "_Q_bar"}, bus.Q_bar, 4'b1111);
      chk({tag, "_changed"}, bus.changed, 4'b0000);
      chk({tag, "_sr_err"}, {3'b0, bus.sr_err}, 4'b0000);
   endtask

   initial begin
      bus.mode = MODE_D; bus.en = 0; bus.a = 0; bus.b = 0; bus.clr = 0; bus.err_clr = 0;
      rst = 1'b1;
      #3 reset_check("rst_init");
      #2 rst = 1'b0;
      model_reset();
      repeat (4) step(1, 4'hF, 4'b0101, 4'h0, 0, 0);
      step(1, 4'hF, 4'h0, 4'h0, 1, 0);
      step(2, 4'hF, 4'b1100, 4'b1010, 0, 0);
      step(2, 4'hF, 4'h0, 4'h0, 0, 0);
      step(0, 4'hF, 4'b0011, 4'h0, 0, 0);
      step(3, 4'hF, 4'b1001, 4'b0001, 0, 0);
      repeat (2) step(3, 4'hF, 4'h0, 4'h0, 0, 0);
      step(3, 4'hF, 4'h0, 4'h0, 0, 1);
      step(3, 4'hF, 4'hF, 4'hF, 0, 1);
      step(0, 4'h0, 4'h0, 4'h0, 0, 1);
      step(0, 4'b0110, 4'hF, 4'h0, 0, 0);
      step(0, 4'hF, 4'hF, 4'h0, 1, 0);
      step(0, 4'hF, 4'h0, 4'h0, 0, 0);
      step(0, 4'hF, 4'b1010, 4'h0, 0, 0);
      step(1, 4'hF, 4'h0, 4'h0, 0, 0);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 reset_check("rst_mid");
      model_reset();
      #1 rst = 1'b0;
      repeat (2) step(1, 4'hF, 4'h0, 4'h0, 0, 0);
      for (int n = 0; n < 300; n++)
         step($urandom_range(0, 3), 4'($urandom), 4'($urandom), 4'($urandom),
              $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
      @(posedge clk);
      #3 chk("sb_drained", 4'(sb.size()), 4'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
